// File: rtl/btn_conditioner_if.sv
// Panel button bundle between the raw push-button inputs and the conditioner.
// master drives the raw buttons; slave is the conditioner producing pulses/levels.
interface btn_conditioner_if #(
  parameter int N_BTN = 7
);
  logic [N_BTN-1:0] btn_raw_n;
  logic [N_BTN-1:0] btn_pulse_n;
  logic [N_BTN-1:0] btn_db_n;

  modport master (
    output btn_raw_n,
    input  btn_pulse_n,
    input  btn_db_n
  );

  modport slave (
    input  btn_raw_n,
    output btn_pulse_n,
    output btn_db_n
  );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronise, debounce and serialise active-low panel buttons into one-cycle pulses.
// Define BTN_SYNC2_EN for the 2-FF synchronizer; otherwise a single sampling register is used.
module btn_conditioner #(
  parameter int N_BTN     = 7,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  btn_conditioner_if.slave bus
);

  localparam int                CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] db_vec;
  logic [N_BTN-1:0] db_prev_reg;
  logic [N_BTN-1:0] pend_reg;
  logic [N_BTN-1:0] pulse_n_reg;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] grant;
  logic             higher;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_bit
      logic             samp;
      logic             s1_reg;
      logic             db_reg;
      logic [CNT_W-1:0] cnt_reg;

`ifdef BTN_SYNC2_EN
      logic s2_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= bus.btn_raw_n[gi];
          s2_reg <= s1_reg;
        end
      end

      assign samp = s2_reg;
`else
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg <= 1'b1;
        end else begin
          s1_reg <= bus.btn_raw_n[gi];
        end
      end

      assign samp = s1_reg;
`endif

      // Any sample agreeing with the accepted level restarts the stability count.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          db_reg  <= 1'b1;
          cnt_reg <= '0;
        end else if (samp == db_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          db_reg  <= samp;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign db_vec[gi] = db_reg;
    end
  endgenerate

  // A press is the debounced level going 1 -> 0; releases are ignored.
  assign fall = db_prev_reg & ~db_vec;

  always_comb begin
    grant  = '0;
    higher = 1'b0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      grant[i] = pend_reg[i] & ~higher;
      higher   = higher | pend_reg[i];
    end
  end

  // New presses merge into pend in the same edge the current winner is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev_reg <= '1;
      pend_reg    <= '0;
      pulse_n_reg <= '1;
    end else begin
      db_prev_reg <= db_vec;
      pend_reg    <= (pend_reg & ~grant) | fall;
      pulse_n_reg <= ~grant;
    end
  end

  assign bus.btn_db_n    = db_vec;
  assign bus.btn_pulse_n = pulse_n_reg;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised scoreboard bench for btn_conditioner against a sample-queue reference model.
module tb_btn_conditioner;

  localparam int N  = 7;
  localparam int DB = 4;
`ifdef BTN_SYNC2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN     (N),
    .DB_CYCLES (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: sync delay as a sample queue, debounce as a run length.
  bit         pipe_m[N][$];
  bit         db_m[N];
  int         run_m[N];
  bit [N-1:0] pend_m;
  bit [N-1:0] fell_m;
  int         g_m;
  bit         samp_m;
  int         exp_idx[$];
  time        exp_t[$];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      pipe_m[i].delete();
      for (int k = 0; k < LAT; k++) pipe_m[i].push_back(1'b1);
      db_m[i]  = 1'b1;
      run_m[i] = 0;
    end
    pend_m = '0;
    fell_m = '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      g_m = -1;
      for (int i = 0; i < N; i++) if (pend_m[i]) g_m = i;
      if (g_m >= 0) begin
        exp_idx.push_back(g_m);
        exp_t.push_back($time);
        pend_m[g_m] = 1'b0;
      end
      pend_m = pend_m | fell_m;
      fell_m = '0;
      for (int i = 0; i < N; i++) begin
        samp_m = pipe_m[i].pop_front();
        pipe_m[i].push_back(bus.btn_raw_n[i]);
        if (samp_m == db_m[i]) begin
          run_m[i] = 0;
        end else begin
          run_m[i]++;
          if (run_m[i] == DB) begin
            db_m[i]  = samp_m;
            run_m[i] = 0;
            if (!samp_m) fell_m[i] = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares levels every cycle and pops the scoreboard on each pulse.
  always @(negedge clk) begin
    logic [N-1:0] dbv;
    logic [N-1:0] want;
    for (int i = 0; i < N; i++) dbv[i] = db_m[i];
    vectors++;
    if (bus.btn_db_n !== dbv) begin
      miscompares++;
      $display("FAIL db_level t=%0t got=%h want=%h", $time, bus.btn_db_n, dbv);
    end
    if (bus.btn_pulse_n !== '1) begin
      vectors++;
      if (exp_idx.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse t=%0t got=%h want=7f", $time, bus.btn_pulse_n);
      end else begin
        want = ~(7'd1 << exp_idx.pop_front());
        if (bus.btn_pulse_n !== want || ($time - exp_t.pop_front()) != 5) begin
          miscompares++;
          $display("FAIL pulse t=%0t got=%h want=%h", $time, bus.btn_pulse_n, want);
        end else begin
          $display("pulse t=%0t value=%h", $time, bus.btn_pulse_n);
        end
      end
    end else if (exp_idx.size() != 0) begin
      vectors++;
      miscompares++;
      want = ~(7'd1 << exp_idx.pop_front());
      void'(exp_t.pop_front());
      $display("FAIL missing_pulse t=%0t got=%h want=%h", $time, bus.btn_pulse_n, want);
    end
  end

  task automatic hold(input logic [N-1:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.btn_raw_n = v;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (bus.btn_pulse_n !== 7'h7F || bus.btn_db_n !== 7'h7F) begin
      miscompares++;
      $display("FAIL %s got pulse=%h db=%h want 7f/7f", name, bus.btn_pulse_n, bus.btn_db_n);
    end else begin
      $display("%s pulse=%h db=%h", name, bus.btn_pulse_n, bus.btn_db_n);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [N-1:0] rnd_v;

  initial begin
    bus.btn_raw_n = '1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    #1 rst_n = 1'b1;
    hold('1, 6);
    check_reset_outputs("idle_after_reset");

    hold(7'h77, 20);                          // clean money_5 press
    hold('1, 12);

    repeat (5) begin                          // tea bouncing
      hold(7'h7E, 2);
      hold('1, 1);
    end
    hold('1, 12);
    hold(7'h7E, 8);                           // tea clean press
    hold('1, 12);

    hold(7'h6E, 10);                          // tea + money_10 together
    hold('1, 12);

    hold(7'h00, 15);                          // all seven together
    hold('1, 15);

    hold(7'h3D, LAT + DB + 2);                // coke + cancel, reset once pend is set
    pulse_reset();
    hold(7'h3D, 10);
    hold('1, 12);

    rnd_v = '1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) rnd_v[i] = ~rnd_v[i];
      hold(rnd_v, 1);
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    hold('1, 40);
    vectors++;
    if (exp_idx.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d pending want=0", exp_idx.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioner for the vending-machine panel. Takes the seven raw, bouncy, active-low push-buttons (tea, coke, sprite, money_5, money_10, money_50, cancel), synchronises and debounces each one, and turns every debounced press into exactly one single-cycle active-low pulse. Pulses are serialised so that at most one is issued per cycle, in fixed priority order. Outputs connect directly to the vending FSM's active-low button inputs.

## Interface

- `N_BTN`, default 7 — number of buttons; the bit map below assumes 7.
- `DB_CYCLES`, default 4 — consecutive stable samples needed to accept a level change; legal range 2..255.
- `clk` input, 1 bit — single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit — reset; asynchronous, active-low.
- `btn_raw_n` input, `N_BTN` bits — raw buttons, 0 = pressed. Bit map: [0] tea, [1] coke, [2] sprite, [3] money_5, [4] money_10, [5] money_50, [6] cancel.
- `btn_pulse_n` output, `N_BTN` bits — registered. At most one bit is 0 in any cycle, for exactly one cycle per accepted press.
- `btn_db_n` output, `N_BTN` bits — registered debounced level, 0 = held.

## Operation

- **Sync:** each bit goes through a 2-FF synchronizer (s1, s2), reset value 1.
- **Debounce (per bit):** state `db` (reset 1) and counter `cnt` (reset 0, width ceil(log2(DB_CYCLES))).
  - If s2 == db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any sample equal to db restarts the count. A glitch shorter than DB_CYCLES s2-samples has no effect.
- **Press event:** a db transition 1→0 sets `pend[i]` on the following edge. A 0→1 transition (release) generates nothing. A held button produces exactly one event, and a new event requires a debounced release first, so `pend[i]` can never be set twice.
- **Arbiter:** each cycle, the highest set bit of `pend` is granted. Priority is cancel > money_50 > money_10 > money_5 > sprite > coke > tea.
  - On the edge: `btn_pulse_n[g]` <= 0, all other bits <= 1, `pend[g]` <= 0.
  - If nothing is pending, `btn_pulse_n` <= all 1.
- **Simultaneous events:** an event arriving in the same edge a grant is issued is merged into `pend`. No event is ever lost.
- **Reset (any time, including mid-debounce or with pend non-zero):** s1, s2, db, `btn_db_n`, `btn_pulse_n` go to all 1; cnt and pend go to 0. In-flight presses are discarded.

## Timing

- Reference point: raw bit falls before rising edge E0 and stays low.
- s1 = 0 at E1, s2 = 0 at E2.
- db and `btn_db_n` fall at E(2+DB_CYCLES).
- pend is set at E(3+DB_CYCLES).
- Pulse is low from E(4+DB_CYCLES) to E(5+DB_CYCLES) if nothing of higher priority is pending. With the default, that is low for the cycle after E8.
- Each competing higher-priority pending event delays a pulse by one cycle. Worst case is 6 cycles of arbitration delay for tea.
- Release: `btn_db_n` rises DB_CYCLES s2-samples after s2 returns high.
- Minimum accepted press width: DB_CYCLES+? is not required. Exactly DB_CYCLES consecutive low s2-samples are sufficient.
- Outputs are purely registered; there is no combinational path from input to output.

## Configuration

- `BTN_SYNC2_EN` defined: 2-FF synchronizer as described.
- `BTN_SYNC2_EN` undefined: single-register sampling; s1 feeds the debounce directly. Every latency above drops by 1 (default pulse after E7). This mode is for the simulation-only/fast-bench build.

## Test plan

- **Reset:** assert `rst_n`=0 mid-sim → `btn_pulse_n` = `btn_db_n` = 7'h7F immediately (asynchronous). Release reset, buttons idle → stays 7'h7F.
- **Single clean press:** money_5 (bit 3) low for 20 cycles, DB_CYCLES=4 → `btn_pulse_n` = 7'h77 for exactly one cycle after E8 (E7 without macro). `btn_db_n[3]`=0 from E6 until 4 cycles after release. No second pulse.
- **Bounce rejection:** tea toggled low 2 cycles / high 1 cycle ×5, then released → no pulse. Then a clean hold ≥ 4 samples → exactly one 7'h7E pulse.
- **Simultaneous press:** tea and money_10 fall in the same cycle → 7'h6F pulse in cycle N, 7'h7E pulse in cycle N+1.
- **All seven at once:** pulses appear on consecutive cycles in the order bit 6, 5, 4, 3, 2, 1, 0, each exactly once.
- **Reset mid-operation:** coke and cancel pressed; pulse `rst_n` low for 1 cycle at E(3+DB_CYCLES) (pend set) → no pulse issued afterwards. Both bits re-debounce and produce pulses only if still held ≥ 4 samples after reset.
